dmem_sync_be: RTL
=================

// Module: dmem_sync_be
// PURPOSE
// Parametrised synchronous data memory for the RV32I core's MEM stage. Replaces the
// 16-word, edge-on-strobe RAM with a clocked array that has a request/response handshake.
// Adds byte/halfword/word access with RV32I funct3 encoding, load sign/zero extension,
// and error reporting for misaligned, illegal or out-of-range accesses.
// PARAMETERS
// DEPTH       256   number of 32-bit words; power of two, >= 4
// ADDR_CHECK  1     1: flag addresses >= DEPTH*4 as errors; 0: wrap on low index bits
// PORTS
// clk         in   1   clock; all state changes on the rising edge
// rst_n       in   1   asynchronous active-low reset
// req_valid   in   1   request present
// req_ready   out  1   request accepted this cycle if req_valid & req_ready
// req_we      in   1   1 = store, 0 = load
// req_funct3  in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// req_addr    in   32  byte address
// req_wdata   in   32  store data; B and H use the low bits
// rsp_valid   out  1   response present; held until rsp_ready
// rsp_ready   in   1   consumer takes the response
// rsp_rdata   out  32  extended load data; 0 for stores and for errors
// rsp_err     out  1   access faulted; no memory update
// BEHAVIOUR
// - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0. The array is NOT cleared; its contents are X until written.
// - req_ready = !rsp_valid | rsp_ready. This is a single-entry response register.
//   Full throughput is 1 request/cycle when rsp_ready is held high.
// - Accept: on a clk edge with req_valid & req_ready.
//   - index = req_addr[$clog2(DEPTH)+1:2]; lane = req_addr[1:0].
//   - Store: the write commits at the accept edge.
//     - Byte enables: B -> 1 lane; H -> lanes {lane+1, lane}; W -> all 4.
//     - Data is replicated: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}.
//   - Load: the word is read at the accept edge. Data is shifted right by 8*lane, then:
//     - B: sign-extend bit 7
//     - BU: zero-extend from 8 bits
//     - H: sign-extend bit 15
//     - HU: zero-extend from 16 bits
//     - W: unchanged
// - Latency: the response appears the cycle after accept (rsp_valid=1). Stores also produce a response (ack).
// - Errors set rsp_err=1 and rsp_rdata=0. They suppress the store (all byte enables 0). Error causes:
//   - H/HU with lane[0]=1; W with lane!=0
//   - store funct3 not in {000,001,010}; load funct3 in {011,110,111}
//   - ADDR_CHECK=1 and req_addr >= DEPTH*4
// - Backpressure: while rsp_valid & !rsp_ready, the response registers hold and req_ready=0.
// - Same-cycle consume+accept: the new response replaces the old with no bubble.
// - Back-to-back store then load to the same word: the load returns the newly stored bytes.
// - Reset mid-operation: a pending response is dropped (rsp_valid->0 asynchronously).
//   A store already accepted stays committed. No write occurs while rst_n=0.
// - Address bits above the index are ignored when ADDR_CHECK=0 (aliasing).
// TESTING
// - SW 0xDEADBEEF @0x10, then LW @0x10 with rsp_ready=1 -> two responses on consecutive cycles; LW rdata=0xDEADBEEF, err=0.
// - SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
// - SH 0x8001 @0x22, LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001; LH @0x21 -> err=1, rdata=0.
// - SW @0x12 (misaligned) then LW @0x10 -> SW response err=1; word unchanged.
//   With DEPTH=256, ADDR_CHECK=1: LW @0x400 -> err=1.
// - Hold rsp_ready=0 for 3 cycles after a load -> req_ready=0 and rsp_rdata stable.
//   Raise rsp_ready with a new req_valid -> next response appears in the next cycle.
// - Assert rst_n=0 while rsp_valid=1 -> rsp_valid/rsp_rdata/rsp_err=0 immediately.
//   After release, a prior accepted SW value is still readable.

Source files
------------

// File: rtl/dmem_sync_be.sv
// dmem_sync_be: clocked RV32I data memory with byte/half/word access and a one-entry response register
module dmem_sync_be #(
  parameter int DEPTH      = 256,
  parameter bit ADDR_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          acc, mis, ill, oor, err;
  logic [3:0]    be;
  logic [31:0]   wd, sh, ld;
  assign req_ready = !rsp_valid | rsp_ready;
  always_comb begin
    idx  = req_addr[AW+1:2];
    lane = req_addr[1:0];
    acc  = req_valid & req_ready;
    mis  = (req_funct3[1:0] == 2'b01 & lane[0]) | (req_funct3[1:0] == 2'b10 & lane != 2'd0);
    ill  = req_we ? req_funct3 > 3'd2 : (req_funct3 == 3'd3 | req_funct3 > 3'd5);
    oor  = ADDR_CHECK & ((req_addr >> (AW + 2)) != 32'd0);
    err  = mis | ill | oor;
    be   = !(acc & req_we & !err) ? 4'b0000 :
           req_funct3[1:0] == 2'b00 ? 4'b0001 << lane :
           req_funct3[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
    wd   = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
           req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    sh   = mem[idx] >> {lane, 3'b000};
    ld   = req_funct3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
           req_funct3 == 3'b100 ? {24'd0, sh[7:0]} :
           req_funct3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
           req_funct3 == 3'b101 ? {16'd0, sh[15:0]} : sh;
  end
  always_ff @(posedge clk)
    if (rst_n)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (err | req_we) ? 32'd0 : ld;
    end else if (rsp_ready) rsp_valid <= 1'b0;
endmodule
